// File: rtl/aes_round_seq.sv
// Iterative AES-128 sequencer: initial AddRoundKey, then loops (state, key, num) through the round pipeline.
// Latency: start at cycle 0 -> valid at cycle NUM_ROUNDS*(L+1)+1 for pipeline latency L (51 for L=4).
// Backpressure: none; one block in flight, start ignored while busy, WAIT aborts with err after TIMEOUT cycles.
module aes_round_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] cipher_key,
    output logic         busy,
    output logic         valid,
    output logic         err,
    output logic [127:0] ciphertext,
    output logic         rnd_en,
    output logic [127:0] rnd_state,
    output logic [127:0] rnd_key,
    output logic [3:0]   rnd_num,
    input  logic         rnd_done,
    input  logic [127:0] rnd_state_out,
    input  logic [127:0] rnd_key_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Counter only needs to reach TIMEOUT; WAIT is left on the cycle it gets there.
    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LAST_NUM  = 4'(NUM_ROUNDS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [127:0]     ciphertext_q, ciphertext_d;
    logic [127:0]     rnd_state_q, rnd_state_d;
    logic [127:0]     rnd_key_q, rnd_key_d;
    logic [3:0]       rnd_num_q, rnd_num_d;
    logic [CNT_W-1:0] tmo_cnt_inc;
    logic             timeout_hit;
    logic             abort;

    assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_inc == TIMEOUT_C);

    // Next-state and datapath: load on start, loop results back, capture final state.
    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        ciphertext_d = ciphertext_q;
        rnd_state_d  = rnd_state_q;
        rnd_key_d    = rnd_key_q;
        rnd_num_d    = rnd_num_q;
        abort        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rnd_state_d = plaintext ^ cipher_key;
                    rnd_key_d   = cipher_key;
                    rnd_num_d   = 4'd1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_inc;
                // A result arriving on the timeout cycle still counts.
                if (rnd_done) begin
                    if (rnd_num_q >= LAST_NUM) begin
                        ciphertext_d = rnd_state_out;
                        state_d      = S_DONE;
                    end else begin
                        rnd_state_d = rnd_state_out;
                        rnd_key_d   = rnd_key_out;
                        rnd_num_d   = rnd_num_q + 4'd1;
                        state_d     = S_ISSUE;
                    end
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight block without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            ciphertext_q <= '0;
            rnd_state_q  <= '0;
            rnd_key_q    <= '0;
            rnd_num_q    <= '0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ciphertext_q <= ciphertext_d;
            rnd_state_q  <= rnd_state_d;
            rnd_key_q    <= rnd_key_d;
            rnd_num_q    <= rnd_num_d;
        end
    end

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign valid      = (state_q == S_DONE);
    assign rnd_en     = (state_q == S_ISSUE);
    assign err        = abort;
    assign ciphertext = ciphertext_q;
    assign rnd_state  = rnd_state_q;
    assign rnd_key    = rnd_key_q;
    assign rnd_num    = rnd_num_q;

endmodule
